// File: rtl/move_pkg.sv
// Shared definitions for the move sequencer: direction codes, FSM states and
// the board<->line mapping used for both gathering and scattering a line.
package move_pkg;

   localparam int TILE_W_DEF  = 20;
   localparam int SCORE_W_DEF = 21;

   localparam logic [2:0] DIR_LEFT  = 3'd0;
   localparam logic [2:0] DIR_RIGHT = 3'd1;
   localparam logic [2:0] DIR_UP    = 3'd2;
   localparam logic [2:0] DIR_DOWN  = 3'd3;
   localparam logic [2:0] DIR_NONE  = 3'd4;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_WRITE,
      ST_SPAWN,
      ST_DONE
   } state_t;

   // Tile number is row*4+col, so {row,col} concatenates directly.
   // Element 0 of a line is always the tile nearest the move direction.
   function automatic logic [3:0] tile_index(input logic [1:0] dir,
                                             input logic [1:0] k,
                                             input logic [1:0] i);
      logic [1:0] ri;
      ri = 2'd3 - i;
      case (dir)
         DIR_LEFT[1:0]:  return {k, i};
         DIR_RIGHT[1:0]: return {k, ri};
         DIR_UP[1:0]:    return {i, k};
         default:        return {ri, k};
      endcase
   endfunction

endpackage

// File: rtl/move_sequencer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for tile spawning.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q <= SEED;
      else      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   end

endmodule

// File: rtl/move_sequencer.sv
// Owns the 4x4 board and score; runs one move line-by-line through an external
// merge unit, writes results back, and spawns a tile after a board change.
module move_sequencer
   import move_pkg::*;
#(
   parameter int          TILE_W    = TILE_W_DEF,
   parameter int          SCORE_W   = SCORE_W_DEF,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           dir,
   input  logic                 ld_en,
   input  logic [16*TILE_W-1:0] ld_board,
   output logic                 ln_req,
   output logic [4*TILE_W-1:0]  ln_data,
   input  logic                 ln_ack,
   input  logic [4*TILE_W-1:0]  ln_result,
   input  logic [SCORE_W-1:0]   ln_points,
   output logic [16*TILE_W-1:0] board,
   output logic [SCORE_W-1:0]   score,
   output logic                 busy,
   output logic                 move_done,
   output logic                 moved
);

   state_t                state_reg, state_next;
   logic [TILE_W-1:0]     tiles_reg [16];
   logic [SCORE_W-1:0]    score_reg;
   logic [SCORE_W-1:0]    points_reg;
   logic [4*TILE_W-1:0]   result_reg;
   logic [1:0]            dir_reg;
   logic [1:0]            k_reg;
   logic                  moved_reg;
   logic [3:0]            probe_reg;
   logic [3:0]            probe_cnt_reg;
   logic                  spawn_first_reg;
   logic                  spawn_again_reg;
   logic                  init_reg;

   logic [15:0]           lfsr_q;
   logic                  unused_lfsr;
   logic [3:0]            probe_idx;
   logic                  probe_empty;
   logic                  spawn_end;
   logic [TILE_W-1:0]     spawn_val;
   logic                  line_changed;
   logic [SCORE_W:0]      score_sum;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_q)
   );

   assign unused_lfsr = ^lfsr_q[15:7];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_gather
         assign ln_data[gi*TILE_W +: TILE_W] = tiles_reg[tile_index(dir_reg, k_reg, 2'(gi))];
      end
      for (gi = 0; gi < 16; gi++) begin : g_board
         assign board[gi*TILE_W +: TILE_W] = tiles_reg[gi];
      end
   endgenerate

   // The first probe of each spawn starts from the live LFSR value.
   assign probe_idx    = spawn_first_reg ? lfsr_q[3:0] : probe_reg;
   assign probe_empty  = (tiles_reg[probe_idx] == '0);
   assign spawn_end    = probe_empty || (probe_cnt_reg == 4'd15);
   assign spawn_val    = (lfsr_q[6:4] == 3'd0) ? TILE_W'(4) : TILE_W'(2);
   assign line_changed = (result_reg != ln_data);
   assign score_sum    = {1'b0, score_reg} + {1'b0, points_reg};

   assign ln_req    = (state_reg == ST_ISSUE);
   assign score     = score_reg;
   assign busy      = (state_reg != ST_IDLE);
   assign move_done = (state_reg == ST_DONE);
   assign moved     = moved_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= ST_INIT;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_INIT:  state_next = ST_SPAWN;
         ST_IDLE:  if (!ld_en && !dir[2]) state_next = ST_ISSUE;
         ST_ISSUE: state_next = ST_WAIT;
         ST_WAIT:  if (ln_ack) state_next = ST_WRITE;
         ST_WRITE: begin
            if (k_reg != 2'd3)                  state_next = ST_ISSUE;
            else if (moved_reg || line_changed) state_next = ST_SPAWN;
            else                                state_next = ST_DONE;
         end
         ST_SPAWN: begin
            if (spawn_end) begin
               if (spawn_again_reg) state_next = ST_SPAWN;
               else if (init_reg)   state_next = ST_IDLE;
               else                 state_next = ST_DONE;
            end
         end
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < 16; t++) tiles_reg[t] <= '0;
         score_reg       <= '0;
         points_reg      <= '0;
         result_reg      <= '0;
         dir_reg         <= '0;
         k_reg           <= '0;
         moved_reg       <= 1'b0;
         probe_reg       <= '0;
         probe_cnt_reg   <= '0;
         spawn_first_reg <= 1'b1;
         spawn_again_reg <= 1'b0;
         init_reg        <= 1'b1;
      end else begin
         case (state_reg)
            ST_INIT: begin
               spawn_first_reg <= 1'b1;
               spawn_again_reg <= 1'b1;
               init_reg        <= 1'b1;
            end
            ST_IDLE: begin
               if (ld_en) begin
                  for (int t = 0; t < 16; t++) tiles_reg[t] <= ld_board[t*TILE_W +: TILE_W];
               end else if (!dir[2]) begin
                  dir_reg   <= dir[1:0];
                  k_reg     <= 2'd0;
                  moved_reg <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (ln_ack) begin
                  result_reg <= ln_result;
                  points_reg <= ln_points;
               end
            end
            ST_WRITE: begin
               for (int i = 0; i < 4; i++)
                  tiles_reg[tile_index(dir_reg, k_reg, 2'(i))] <= result_reg[i*TILE_W +: TILE_W];
               moved_reg <= moved_reg | line_changed;
               score_reg <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
               k_reg     <= k_reg + 2'd1;
               if (k_reg == 2'd3) begin
                  spawn_first_reg <= 1'b1;
                  spawn_again_reg <= 1'b0;
                  init_reg        <= 1'b0;
               end
            end
            ST_SPAWN: begin
               spawn_first_reg <= 1'b0;
               probe_reg       <= probe_idx + 4'd1;
               probe_cnt_reg   <= probe_cnt_reg + 4'd1;
               if (probe_empty) tiles_reg[probe_idx] <= spawn_val;
               if (spawn_end) begin
                  probe_cnt_reg   <= '0;
                  spawn_first_reg <= 1'b1;
                  spawn_again_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench: a merge-unit responder answers line requests and checks issued
// lines; a monitor scores every move_done against queued expected outcomes.
module tb_move_sequencer;

   localparam int TW = 20;
   localparam int SW = 21;

   typedef struct {
      logic [16*TW-1:0] board;
      logic [SW-1:0]    score;
      logic             moved;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [2:0]        dir = 3'd4;
   logic              ld_en = 1'b0;
   logic [16*TW-1:0]  ld_board = '0;
   logic              ln_req;
   logic [4*TW-1:0]   ln_data;
   logic              ln_ack = 1'b0;
   logic [4*TW-1:0]   ln_result = '0;
   logic [SW-1:0]     ln_points = '0;
   logic [16*TW-1:0]  board;
   logic [SW-1:0]     score;
   logic              busy;
   logic              move_done;
   logic              moved;

   move_sequencer #(.TILE_W(TW), .SCORE_W(SW), .LFSR_SEED(16'hACE1)) dut (
      .clk       (clk),
      .rst       (rst),
      .dir       (dir),
      .ld_en     (ld_en),
      .ld_board  (ld_board),
      .ln_req    (ln_req),
      .ln_data   (ln_data),
      .ln_ack    (ln_ack),
      .ln_result (ln_result),
      .ln_points (ln_points),
      .board     (board),
      .score     (score),
      .busy      (busy),
      .move_done (move_done),
      .moved     (moved)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int req_total = 0;
   int done_count = 0;
   int ack_delay = 1;
   bit bad_ack = 1'b0;
   int stall_at = -1;
   logic [4*TW-1:0] exp_line_q[$];
   exp_t            exp_q[$];
   logic [SW-1:0]   score_model = '0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   function automatic int tidx(input int d, input int k, input int i);
      case (d)
         0:       return k*4 + i;
         1:       return k*4 + 3 - i;
         2:       return i*4 + k;
         default: return (3-i)*4 + k;
      endcase
   endfunction

   function automatic logic [4*TW-1:0] pack_line(input int l[4]);
      logic [4*TW-1:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[i*TW +: TW] = TW'(l[i]);
      return r;
   endfunction

   function automatic logic [16*TW-1:0] pack_board(input int t[16]);
      logic [16*TW-1:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[i*TW +: TW] = TW'(t[i]);
      return r;
   endfunction

   // Reference 2048 line merge: compact toward element 0, merge equal pairs once.
   function automatic void merge_line(input int lin[4], output int lout[4], output int pts);
      int c[4];
      int n, o, j;
      n = 0; o = 0; j = 0; pts = 0;
      for (int i = 0; i < 4; i++) begin lout[i] = 0; c[i] = 0; end
      for (int i = 0; i < 4; i++) if (lin[i] != 0) begin c[n] = lin[i]; n++; end
      while (j < n) begin
         if (j + 1 < n && c[j] == c[j+1]) begin
            lout[o] = 2*c[j]; pts += 2*c[j]; j += 2;
         end else begin
            lout[o] = c[j]; j++;
         end
         o++;
      end
   endfunction

   initial begin : responder
      logic [4*TW-1:0] line_in;
      int lin[4];
      int lout[4];
      int pts;
      forever begin
         @(negedge clk);
         if (rst && ln_req) begin
            req_total++;
            line_in = ln_data;
            $display("line request %0d: data=%h", req_total, line_in);
            if (exp_line_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL ln_req_unexpected: got request %h, required none", line_in);
            end else begin
               chk("ln_data", line_in, exp_line_q.pop_front());
            end
            if (req_total != stall_at) begin
               for (int i = 0; i < 4; i++) lin[i] = int'(line_in[i*TW +: TW]);
               merge_line(lin, lout, pts);
               if (bad_ack) begin
                  ln_ack = 1'b1; ln_result = {4*TW{1'b1}}; ln_points = SW'(12345);
               end
               for (int c = 0; c < ack_delay && rst; c++) begin
                  @(negedge clk); ln_ack = 1'b0;
               end
               if (rst) begin
                  chk("ln_data_hold", ln_data, line_in);
                  ln_ack = 1'b1; ln_result = pack_line(lout); ln_points = SW'(pts);
                  @(negedge clk);
               end
               ln_ack = 1'b0;
            end
         end
      end
   end

   initial begin : monitor
      exp_t e;
      int diffs, a, x;
      bit good;
      forever begin
         @(negedge clk);
         if (rst && move_done) begin
            done_count++;
            $display("move done %0d: moved=%0b score=%0d", done_count, moved, score);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL move_done_unexpected: got pulse, required none");
            end else begin
               e = exp_q.pop_front();
               chk("moved", moved, e.moved);
               chk("score", score, e.score);
               diffs = 0; good = 1'b1;
               for (int t = 0; t < 16; t++) begin
                  a = int'(board[t*TW +: TW]);
                  x = int'(e.board[t*TW +: TW]);
                  if (a != x) begin
                     diffs++;
                     if (x != 0 || (a != 2 && a != 4)) good = 1'b0;
                  end
               end
               checks++;
               if (!(good && diffs == (e.moved ? 1 : 0))) begin
                  errors++;
                  $display("FAIL board: got %h required %h plus %0d spawned tile", board, e.board, e.moved);
               end
            end
         end
      end
   end

   task automatic wait_idle(input int budget, input string nm);
      int n;
      n = 0;
      while (busy && n < budget) begin @(negedge clk); n++; end
      chk({nm, "_idle"}, busy, 1'b0);
   endtask

   task automatic check_init(input int done_before);
      int nz, v;
      bit ok;
      nz = 0; ok = 1'b1;
      wait_idle(40, "init");
      for (int t = 0; t < 16; t++) begin
         v = int'(board[t*TW +: TW]);
         if (v != 0) begin
            nz++;
            if (v != 2 && v != 4) ok = 1'b0;
         end
      end
      chk("init_tiles", nz, 2);
      chk("init_vals", ok, 1'b1);
      chk("init_score", score, 0);
      chk("init_no_done", done_count, done_before);
   endtask

   task automatic do_move(input int d, input int t[16], input int ack_d, input bit bad, input bit extra);
      int nb[16];
      int lin[4];
      int lout[4];
      int pts, req0, done0, n;
      bit mv;
      exp_t e;
      logic [SW:0] s;
      wait_idle(200, "pre_move");
      ld_board = pack_board(t); ld_en = 1'b1;
      @(negedge clk);
      ld_en = 1'b0;
      nb = t; mv = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 4; i++) lin[i] = t[tidx(d, k, i)];
         exp_line_q.push_back(pack_line(lin));
         merge_line(lin, lout, pts);
         for (int i = 0; i < 4; i++) begin
            nb[tidx(d, k, i)] = lout[i];
            if (lout[i] != lin[i]) mv = 1'b1;
         end
         s = {1'b0, score_model} + (SW+1)'(pts);
         score_model = s[SW] ? {SW{1'b1}} : s[SW-1:0];
      end
      e.board = pack_board(nb); e.score = score_model; e.moved = mv;
      exp_q.push_back(e);
      ack_delay = ack_d; bad_ack = bad;
      req0 = req_total; done0 = done_count;
      dir = 3'(d);
      @(negedge clk);
      dir = 3'd4;
      n = 0;
      while (done_count == done0 && n < 400) begin
         if (extra && n == 3)       dir = 3'd3;
         else if (extra && n == 10) dir = 3'd5;
         else                       dir = 3'd4;
         @(negedge clk);
         n++;
      end
      dir = 3'd4;
      chk("move_completed", done_count, done0 + 1);
      chk("ln_req_count", req_total - req0, 4);
      if (extra) begin
         repeat (30) @(negedge clk);
         chk("no_second_move", done_count, done0 + 1);
         chk("no_extra_req", req_total - req0, 4);
         chk("idle_after", busy, 1'b0);
      end
      bad_ack = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int t[16];
      int req0, n, done0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b1);
      chk("rst_ln_req", ln_req, 1'b0);
      chk("rst_move_done", move_done, 1'b0);
      chk("rst_score", score, 0);
      chk("rst_board_any", |board, 1'b0);
      rst = 1'b1;
      check_init(0);

      // Row 0 = [2,2,0,0], move left.
      t = '{2,2,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
      do_move(0, t, 2, 1'b0, 1'b0);

      // Every row [2,4,8,16], move left: nothing changes, no spawn.
      t = '{2,4,8,16, 2,4,8,16, 2,4,8,16, 2,4,8,16};
      do_move(0, t, 1, 1'b0, 1'b0);

      // Single tile at 12, move up.
      t = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 2,0,0,0};
      do_move(2, t, 3, 1'b0, 1'b0);

      // Move right with slow acks, early bogus ack and ignored extra dirs.
      t = '{0,0,0,0, 4,4,4,4, 0,0,0,0, 0,0,0,0};
      do_move(1, t, 7, 1'b1, 1'b1);

      // Reset while waiting on line 2.
      wait_idle(200, "pre_reset");
      t = '{2,2,0,0, 0,0,0,0, 8,0,0,8, 0,0,0,0};
      ld_board = pack_board(t); ld_en = 1'b1;
      @(negedge clk);
      ld_en = 1'b0;
      exp_line_q.push_back(pack_line('{2,2,0,0}));
      exp_line_q.push_back(pack_line('{0,0,0,0}));
      exp_line_q.push_back(pack_line('{8,0,0,8}));
      ack_delay = 1;
      req0 = req_total;
      stall_at = req0 + 3;
      dir = 3'd0;
      @(negedge clk);
      dir = 3'd4;
      n = 0;
      while (req_total < req0 + 3 && n < 200) begin @(negedge clk); n++; end
      chk("reached_line2", req_total - req0, 3);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_board_any", |board, 1'b0);
      chk("abort_score", score, 0);
      chk("abort_ln_req", ln_req, 1'b0);
      chk("abort_busy", busy, 1'b1);
      exp_line_q.delete();
      stall_at = -1;
      score_model = '0;
      done0 = done_count;
      @(negedge clk);
      rst = 1'b1;
      check_init(done0);
      req0 = req_total;
      repeat (20) @(negedge clk);
      chk("aborted_move_gone", done_count, done0);
      chk("aborted_no_req", req_total, req0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Owns the 4x4 game board and score register. Sequences one move through a shared single-line merge unit: issues the four lines in direction order, writes back the results and accumulates points. After any move that changed the board it spawns a new tile via an LFSR probe. It sits between the direction input logic and the line merge datapath, and drives the board/score consumed by the display path.

Parameters:
TILE_W, 20, bits per tile (tile holds its literal value: 2, 4, 8, ...)
SCORE_W, 21, score width; score saturates at 2^SCORE_W-1
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
dir  in  3  move request: 0=left 1=right 2=up 3=down; 4..7=none
ld_en  in  1  board preload strobe (test/config)
ld_board  in  16*TILE_W  preload value
ln_req  out  1  one-cycle pulse: ln_data valid for merge unit
ln_data  out  4*TILE_W  line to merge; element 0 is the front (toward the move)
ln_ack  in  1  merge result valid
ln_result  in  4*TILE_W  merged line, packed toward element 0
ln_points  in  SCORE_W  sum of tile values created by merges in this line
board  out  16*TILE_W  tile t=row*4+col at board[t*TILE_W +: TILE_W]
score  out  SCORE_W  accumulated score
busy  out  1  high in every state except IDLE
move_done  out  1  one-cycle pulse when a move completes (moved or not)
moved  out  1  valid with move_done: 1 if any line changed

Behaviour:
- Reset (async, rst=0): board=0, score=0, ln_req=0, move_done=0, moved=0, LFSR=LFSR_SEED, state=INIT. busy=1 from release until INIT finishes.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in all states.
- States: INIT -> SPAWN (twice) -> IDLE; IDLE -> ISSUE -> WAIT -> WRITE -> (ISSUE for next line | SPAWN | DONE); SPAWN -> DONE; DONE -> IDLE.
- IDLE: dir in 0..3 sampled on a clk edge captures dir, sets line k=0, clears the moved accumulator, and goes to ISSUE. dir 4..7 is ignored. dir is ignored in all other states; there is no queueing. ld_en in IDLE: board<=ld_board next cycle, score unchanged. ld_en outside IDLE is ignored. If ld_en and a valid dir are present together, ld_en wins and the dir is dropped.
- Line mapping for line k, element i:
  - left: tile(k,i)
  - right: tile(k,3-i)
  - up: tile(i,k)
  - down: tile(3-i,k)
- ISSUE: ln_req=1 for exactly one cycle, ln_data driven per mapping and held stable until ack. Next state WAIT.
- WAIT: stay until ln_ack=1. An ack in the same cycle as ln_req is ignored; ack latency is unbounded. On ack, capture ln_result and ln_points.
- WRITE: scatter the result back through the same mapping. moved |= (result != issued line). score <= min(score + points, 2^SCORE_W-1). k++; if k was 3, go to SPAWN when moved=1, else DONE.
- SPAWN: probe index p starts at lfsr[3:0], +1 mod 16 each cycle. First empty tile gets value 4 if lfsr[6:4]==0 else 2. Give up after 16 probes with no empty tile (board unchanged). INIT uses the same routine twice.
- DONE: move_done=1 and moved valid for one cycle, then IDLE. INIT does not pulse move_done.
- Latency: 4*(2+ack latency)+1 cycles to the end of WRITE, plus 1..16 spawn cycles, plus 1 DONE cycle.
- A reset asserted mid-move aborts immediately: ln_req drops, partial writes are lost, and the block re-enters INIT on release.

Decomposition:
- Shared package move_pkg: dir codes (DIR_LEFT..DIR_DOWN, DIR_NONE=4), state enum, TILE_W/SCORE_W defaults, tile_index(dir,k,i) function used for both gather and scatter.
- One sub-module: lfsr16 (clk, rst, q[15:0], seed parameter).

Test Plan:
- Reset release -> within 40 cycles busy=0, exactly two nonzero tiles each in {2,4}, score=0, no move_done pulse.
- Preload row0=[2,2,0,0], rest 0; dir=0; bench merge model returns [4,0,0,0] with points=4 (lines 1-3 all zero, points 0) -> tile0=4, tiles1..3=0, score=4, moved=1, exactly one new tile in {2,4} among the empties, one move_done pulse.
- Preload every row=[2,4,8,16]; dir=0 -> four ln_req pulses, moved=0, board bit-identical, score unchanged, no spawn.
- Preload tile12=2, rest 0; dir=2 (up) -> line0 ln_data elements 0..3 = tiles 0,4,8,12 = [0,0,0,2]; with result [2,0,0,0], tile0=2, tile12=0 before spawn.
- Merge model acks after 7 cycles; dir=1 pulsed, and dir=3/dir=5 applied while busy -> only one move runs, four ln_req pulses, no second move; ack asserted with ln_req is not accepted.
- rst=0 while in WAIT of line 2 -> board=0, score=0, ln_req=0 immediately; after release, INIT spawns two tiles and the previous move never completes.
